// File: rtl/rx_packet_fifo_if.sv
// rx_packet_fifo_if
// Bundles the receive-side handshake and the core-side handshake of the
// receive packet buffer.
//   RX_Data / RX_Data_Valid / RX_Ready : packet arrival from the receiver
//   Pkt_Data / Pkt_Valid / Pkt_Ack     : head packet delivery to the core
//   Count                              : number of stored packets
// Modport slave is taken by the buffer; modport master is taken by whatever
// drives the buffer (receiver plus core, or a testbench).
interface rx_packet_fifo_if #(
    parameter int WIDTH  = 55,
    parameter int ADDR_W = 2
);
    logic [WIDTH-1:0] RX_Data;
    logic             RX_Data_Valid;
    logic             RX_Ready;
    logic [WIDTH-1:0] Pkt_Data;
    logic             Pkt_Valid;
    logic             Pkt_Ack;
    logic [ADDR_W:0]  Count;

    modport slave (
        input  RX_Data, RX_Data_Valid, Pkt_Ack,
        output RX_Ready, Pkt_Data, Pkt_Valid, Count
    );

    modport master (
        output RX_Data, RX_Data_Valid, Pkt_Ack,
        input  RX_Ready, Pkt_Data, Pkt_Valid, Count
    );
endinterface

// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo
// First-word-fall-through packet queue between the serial-link receiver and
// the router core. Holds up to DEPTH packets so back-to-back arrivals are
// not stalled in the receiver.
// Ports:
//   Clk_S  : single clock, rising edge
//   Rst_n  : asynchronous active-low reset
//   bus    : rx_packet_fifo_if.slave (RX_* from receiver, Pkt_* to core,
//            Count of stored packets)
// All flags are registered from the next-state occupancy, so no output
// depends combinationally on RX_Data_Valid or Pkt_Ack. Pkt_Data is read
// straight from storage at the read pointer.
module rx_packet_fifo #(
    parameter int WIDTH  = 55,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                 Clk_S,
    input  logic                 Rst_n,
    rx_packet_fifo_if.slave      bus
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_next;
    logic              rx_ready_q;
    logic              pkt_valid_q;
    logic              push;
    logic              pop;

    // Handshakes only qualify on the registered flags, which is what makes
    // overflow and underflow impossible.
    assign push = bus.RX_Data_Valid & rx_ready_q;
    assign pop  = bus.Pkt_Ack & pkt_valid_q;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + 1'b1;
        end else if (pop && !push) begin
            count_next = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rx_ready_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Occupancy alone tells full from empty; pointers may be equal
            // in both cases after a wrap.
            count_q     <= count_next;
            rx_ready_q  <= (count_next != FULL_COUNT);
            pkt_valid_q <= (count_next != '0);
        end
    end

    // NOTE: packet storage has no reset; the pointers and Count reset, so
    // stale slots are never presented as valid and clearing them buys nothing.
    always_ff @(posedge Clk_S) begin
        if (push) begin
            mem[wr_ptr] <= bus.RX_Data;
        end
    end

    assign bus.Pkt_Data  = mem[rd_ptr];
    assign bus.Pkt_Valid = pkt_valid_q;
    assign bus.RX_Ready  = rx_ready_q;
    assign bus.Count     = count_q;

endmodule

// File: tb/tb_rx_packet_fifo.sv
// tb_rx_packet_fifo
// Directed bench for rx_packet_fifo. A queue-based reference model tracks
// which packets should be stored; a compare process checks Count, RX_Ready,
// Pkt_Valid and the head packet on every falling edge. Directed sections add
// hand-computed literal expectations that pin the model itself.
module tb_rx_packet_fifo;

    localparam int WIDTH  = 55;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic Clk_S = 1'b0;
    logic Rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    rx_packet_fifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    rx_packet_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk_S (Clk_S),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    always #5 Clk_S = ~Clk_S;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] model_q[$];
    bit               in_reset = 1'b1;

    always @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            model_q.delete();
            in_reset = 1'b1;
        end else if (in_reset) begin
            // First edge after release only raises RX_Ready.
            in_reset = 1'b0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = bus.Pkt_Ack && (model_q.size() > 0);
            do_push = bus.RX_Data_Valid && (model_q.size() < DEPTH);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(bus.RX_Data);
        end
    end

    always @(negedge Clk_S) begin
        check("model_count", 64'(bus.Count), 64'(model_q.size()));
        check("model_ready", 64'(bus.RX_Ready),
              64'(!in_reset && model_q.size() != DEPTH));
        check("model_valid", 64'(bus.Pkt_Valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0)
            check("model_head", 64'(bus.Pkt_Data), 64'(model_q[0]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk_S);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        bus.RX_Data_Valid = 1'b0;
        bus.Pkt_Ack       = 1'b1;
        while (bus.Pkt_Valid && n < 20) begin
            tick();
            n++;
        end
        bus.Pkt_Ack = 1'b0;
        check("drain_empty", 64'(bus.Pkt_Valid), 64'd0);
    endtask

    logic [WIDTH-1:0] wrap_pkts [10];
    logic [WIDTH-1:0] recv      [10];

    initial begin
        bus.RX_Data       = '0;
        bus.RX_Data_Valid = 1'b0;
        bus.Pkt_Ack       = 1'b0;

        // Reset held for 5 cycles.
        repeat (5) begin
            @(negedge Clk_S);
            #1;
            check("rst_ready", 64'(bus.RX_Ready), 64'd0);
            check("rst_valid", 64'(bus.Pkt_Valid), 64'd0);
            check("rst_count", 64'(bus.Count), 64'd0);
        end
        Rst_n = 1'b1;
        tick();
        check("release_ready", 64'(bus.RX_Ready), 64'd1);

        // Single packet.
        bus.RX_Data = 55'd3; bus.RX_Data_Valid = 1'b1;
        tick();
        bus.RX_Data_Valid = 1'b0;
        check("single_valid", 64'(bus.Pkt_Valid), 64'd1);
        check("single_data", 64'(bus.Pkt_Data), 64'd3);
        check("single_count", 64'(bus.Count), 64'd1);
        bus.Pkt_Ack = 1'b1;
        tick();
        bus.Pkt_Ack = 1'b0;
        check("single_pop_valid", 64'(bus.Pkt_Valid), 64'd0);
        check("single_pop_count", 64'(bus.Count), 64'd0);

        // Ack while empty is ignored.
        bus.Pkt_Ack = 1'b1;
        tick();
        bus.Pkt_Ack = 1'b0;
        check("empty_ack_count", 64'(bus.Count), 64'd0);

        // Fill to DEPTH, then hold a 5th packet against back-pressure.
        for (int i = 1; i <= 4; i++) begin
            bus.RX_Data = WIDTH'(i); bus.RX_Data_Valid = 1'b1;
            tick();
        end
        check("full_ready", 64'(bus.RX_Ready), 64'd0);
        check("full_count", 64'(bus.Count), 64'd4);
        bus.RX_Data = 55'h5;
        tick();
        tick();
        check("full_hold_count", 64'(bus.Count), 64'd4);
        check("full_hold_head", 64'(bus.Pkt_Data), 64'h1);
        bus.Pkt_Ack = 1'b1;
        tick();
        bus.Pkt_Ack = 1'b0;
        check("unfull_head", 64'(bus.Pkt_Data), 64'h2);
        check("unfull_ready", 64'(bus.RX_Ready), 64'd1);
        check("unfull_count", 64'(bus.Count), 64'd3);
        tick();
        bus.RX_Data_Valid = 1'b0;
        check("fifth_count", 64'(bus.Count), 64'd4);
        check("fifth_ready", 64'(bus.RX_Ready), 64'd0);
        drain();

        // Simultaneous push/pop at Count=2.
        bus.RX_Data_Valid = 1'b1;
        bus.RX_Data = 55'd10; tick();
        bus.RX_Data = 55'd11; tick();
        check("sim_start_count", 64'(bus.Count), 64'd2);
        bus.Pkt_Ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.RX_Data = WIDTH'(20 + i);
            tick();
            check("sim_count", 64'(bus.Count), 64'd2);
        end
        bus.RX_Data_Valid = 1'b0;
        bus.Pkt_Ack       = 1'b0;
        check("sim_head", 64'(bus.Pkt_Data), 64'd26);
        drain();

        // Wrap-around with random ack rate.
        for (int i = 0; i < 10; i++) wrap_pkts[i] = WIDTH'(64'h1000 + 64'(i * 7));
        wrap_pkts[4] = 55'b101101110_1110001110_101101110_1110001110_101101110_11101;
        begin
            int sent = 0;
            int got  = 0;
            int cyc  = 0;
            while (got < 10 && cyc < 300) begin
                bit will_push;
                bit will_pop;
                bus.RX_Data_Valid = (sent < 10);
                bus.RX_Data       = (sent < 10) ? wrap_pkts[sent] : '0;
                bus.Pkt_Ack       = 1'($urandom_range(0, 1));
                will_push = bus.RX_Data_Valid && bus.RX_Ready;
                will_pop  = bus.Pkt_Ack && bus.Pkt_Valid;
                if (will_pop) begin
                    recv[got] = bus.Pkt_Data;
                    got++;
                end
                tick();
                if (will_push) sent++;
                cyc++;
            end
            bus.RX_Data_Valid = 1'b0;
            bus.Pkt_Ack       = 1'b0;
            check("wrap_received", 64'(got), 64'd10);
            for (int i = 0; i < got; i++)
                check("wrap_order", 64'(recv[i]), 64'(wrap_pkts[i]));
        end
        check("wrap_end_count", 64'(bus.Count), 64'd0);

        // Reset mid-operation at Count=3.
        bus.RX_Data_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.RX_Data = WIDTH'(8'h31 + i);
            tick();
        end
        bus.RX_Data_Valid = 1'b0;
        check("mid_pre_count", 64'(bus.Count), 64'd3);
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.Pkt_Valid), 64'd0);
        check("mid_rst_ready", 64'(bus.RX_Ready), 64'd0);
        check("mid_rst_count", 64'(bus.Count), 64'd0);
        #20;
        Rst_n = 1'b1;
        tick();
        check("mid_release_ready", 64'(bus.RX_Ready), 64'd1);
        bus.RX_Data_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.RX_Data = WIDTH'(8'h41 + i);
            tick();
        end
        bus.RX_Data_Valid = 1'b0;
        check("mid_new_head", 64'(bus.Pkt_Data), 64'h41);
        check("mid_new_count", 64'(bus.Count), 64'd3);
        drain();

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_packet_fifo.md
# rx_packet_fifo

Receive-side packet buffer that sits directly downstream of `receiver` in each router link. It accepts 55-bit packets from the receiver over the `RX_Data`/`RX_Data_Valid`/`RX_Ready` handshake and stores up to `DEPTH` of them in a first-word-fall-through queue. It presents them to the router core over a valid/ack handshake. The buffer decouples serial-link arrival from core consumption, so back-to-back packets are not stalled in the receiver.

## Interface
- `WIDTH`, default 55: packet width; must match the receiver's `RX_Data`.
- `DEPTH`, default 4: packet slots; power of two, at least 2.
- `ADDR_W`, default 2: log2(`DEPTH`).
- `Clk_S`, input, 1: the single clock; all state updates on the rising edge.
- `Rst_n`, input, 1: reset, asynchronous and active-low.
- `RX_Data`, input, `WIDTH`: packet from the receiver.
- `RX_Data_Valid`, input, 1: receiver holds a complete packet.
- `RX_Ready`, output, 1: buffer can accept a packet this cycle.
- `Pkt_Data`, output, `WIDTH`: head-of-queue packet to the core.
- `Pkt_Valid`, output, 1: `Pkt_Data` is valid.
- `Pkt_Ack`, input, 1: core consumes the head packet.
- `Count`, output, `ADDR_W+1`: number of stored packets, 0..`DEPTH`.

## Operation
- **Push.** A push occurs on a rising edge where `RX_Data_Valid & RX_Ready`.
  - `RX_Data` is written to `mem[wr_ptr]`.
  - `wr_ptr` increments modulo `DEPTH`.
- **Pop.** A pop occurs on a rising edge where `Pkt_Valid & Pkt_Ack`.
  - `rd_ptr` increments modulo `DEPTH`.
  - `Pkt_Ack` with `Pkt_Valid`=0 is ignored.
- **Count update.** `count_next = Count + push - pop`. Simultaneous push and pop leaves `Count` unchanged and both pointers advance.
- **Registered flags.** All three are registered from `count_next`, so there is no combinational path from `RX_Data_Valid` or `Pkt_Ack` to any output.
  - `RX_Ready <= (count_next != DEPTH)`.
  - `Pkt_Valid <= (count_next != 0)`.
  - `Count <= count_next`.
- **Head data.** `Pkt_Data = mem[rd_ptr]`, read combinationally from storage.
  - `Pkt_Data` must stay stable while `Pkt_Valid & !Pkt_Ack`.
  - When `Pkt_Valid`=0, `Pkt_Data` is don't-care.
- **Full.** `RX_Ready`=0, so no push can occur and the receiver holds its packet. Overflow is impossible by construction.
- **Empty.** `Pkt_Valid`=0, so no pop can occur. Underflow is impossible by construction.
- **Wrap-around.** Pointers are `ADDR_W` bits and wrap naturally. `Count` alone distinguishes full from empty; pointer equality is never used for that.
- **Reset.** Reset is asynchronous and may be asserted mid-operation.
  - `Rst_n`=0 immediately forces `RX_Ready`=0, `Pkt_Valid`=0, `Count`=0 and both pointers to 0.
  - Stored packets are discarded. Memory contents are not reset.

## Timing
- **Reset values:** `RX_Ready`=0, `Pkt_Valid`=0, `Count`=0; `Pkt_Data` is don't-care.
- **After reset release:** `RX_Ready` rises on the first rising edge of `Clk_S` after `Rst_n` deasserts.
- **Write-to-read latency is 1 cycle:** a push on edge k makes `Pkt_Valid`=1 and `Pkt_Data` equal to that packet immediately after edge k.
- **Full response:** the push that fills the buffer on edge k drops `RX_Ready` immediately after edge k. A pop on edge j from the full state raises `RX_Ready` after edge j.
- **Last-packet pop:** popping the last packet on edge k drops `Pkt_Valid` after edge k. A simultaneous push on the same edge keeps `Pkt_Valid`=1 with the new packet at the head.
- **Sustained throughput:** one push and one pop per cycle when 0 < `Count` < `DEPTH`.

## Test plan
- **Reset:** hold `Rst_n`=0 for 5 cycles, then release -> `RX_Ready`=0, `Pkt_Valid`=0 and `Count`=0 during reset; `RX_Ready`=1 one edge after release.
- **Single packet:** push 55'd3 with `Pkt_Ack`=0 -> after 1 edge `Pkt_Valid`=1, `Pkt_Data`=55'd3, `Count`=1. Then pulse `Pkt_Ack` for 1 cycle -> `Pkt_Valid`=0, `Count`=0.
- **Fill:** push 4 packets 55'h1..55'h4 with no ack -> `RX_Ready`=0 after the 4th edge, `Count`=4. With a 5th packet held on `RX_Data_Valid`, `Count` stays 4. One ack -> head 55'h2, `RX_Ready`=1; the 5th packet is accepted next edge.
- **Simultaneous push/pop:** at `Count`=2, hold `RX_Data_Valid` and `Pkt_Ack` high for 8 cycles -> `Count` stays 2 and packets emerge in arrival order.
- **Wrap-around:** push and pop 10 packets, including 55'b101101110_1110001110_101101110_1110001110_101101110_11101, at random ack rates -> all emerge in order and uncorrupted through multiple pointer wraps.
- **Reset mid-operation:** assert `Rst_n`=0 at `Count`=3 -> `Pkt_Valid`, `RX_Ready` and `Count` go to 0 without waiting for a clock edge. After release and 3 new pushes, only the new packets emerge.
